// File: rtl/note_sequencer.sv
// Note-code owner for the piezo generator: live keypad passthrough plus a tick-quantised record/playback engine.
// Optional NOTE_SEQ_LOOP_EN: playback wraps to entry 0 at end of sequence instead of returning to IDLE.
module note_sequencer #(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int TICK_DIV = 25000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    key_data,
   input  logic          rec_btn,
   input  logic          play_btn,
   input  logic          stop_btn,
   output logic [3:0]    note_data,
   output logic          busy,
   output logic          rec_full,
   output logic [AW:0]   entry_cnt,
   output logic [1:0]    state
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [AW:0]   LAST_CNT  = (AW + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REC   = 2'd1,
      S_FETCH = 2'd2,
      S_PLAY  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [3:0]      cur_q, cur_d;
   logic [3:0]      dur_q, dur_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     entry_cnt_q, entry_cnt_d;
   logic            rec_full_q, rec_full_d;
   logic [3:0]      play_code_q, play_code_d;
   logic [3:0]      play_dur_q, play_dur_d;
   logic [3:0]      note_q, note_d;
   logic            busy_q, busy_d;

   logic            tick;
   logic            leading;
   logic            wr_en;
   logic [7:0]      wr_data;
   logic            load;

   logic [7:0]      mem [DEPTH];

   assign tick    = (presc_q == TICK_LAST);
   assign leading = (cur_q == 4'd0) && (entry_cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      dur_d       = dur_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      entry_cnt_d = entry_cnt_q;
      rec_full_d  = rec_full_q;
      play_code_d = play_code_q;
      play_dur_d  = play_dur_q;
      wr_en       = 1'b0;
      wr_data     = {cur_q, dur_q};
      load        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (stop_btn) begin
               state_d = S_IDLE;
            end else if (rec_btn) begin
               state_d     = S_REC;
               entry_cnt_d = '0;
               wr_ptr_d    = '0;
               rec_full_d  = 1'b0;
               cur_d       = key_data;
               dur_d       = 4'd0;
            end else if (play_btn && (entry_cnt_q != '0)) begin
               state_d  = S_FETCH;
               rd_ptr_d = '0;
               load     = 1'b1;
            end
         end

         S_REC: begin
            // Buttons beat key changes, key changes beat ticks; at most one write per cycle.
            if (stop_btn || rec_btn) begin
               wr_en   = (dur_q != 4'd0) && !leading;
               state_d = S_IDLE;
            end else if (key_data != cur_q) begin
               wr_en = (dur_q != 4'd0) && !leading;
               cur_d = key_data;
               dur_d = 4'd0;
            end else if (tick) begin
               if (dur_q == 4'd14) begin
                  wr_en   = !leading;
                  wr_data = {cur_q, 4'd15};
                  dur_d   = 4'd0;
               end else begin
                  dur_d = dur_q + 4'd1;
               end
            end
            if (wr_en) begin
               wr_ptr_d    = wr_ptr_q + 1'b1;
               entry_cnt_d = entry_cnt_q + 1'b1;
               if (entry_cnt_q == LAST_CNT) begin
                  rec_full_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end

         S_FETCH: begin
            state_d = stop_btn ? S_IDLE : S_PLAY;
         end

         S_PLAY: begin
            if (stop_btn) begin
               state_d = S_IDLE;
            end else if (tick) begin
               if (play_dur_q <= 4'd1) begin
                  if ({1'b0, rd_ptr_q} == entry_cnt_q - 1'b1) begin
`ifdef NOTE_SEQ_LOOP_EN
                     state_d  = S_FETCH;
                     rd_ptr_d = '0;
                     load     = 1'b1;
`else
                     state_d  = S_IDLE;
`endif
                  end else begin
                     state_d  = S_FETCH;
                     rd_ptr_d = rd_ptr_q + 1'b1;
                     load     = 1'b1;
                  end
               end else begin
                  play_dur_d = play_dur_q - 4'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Entry is read as FETCH is entered so the new code is already driven during FETCH.
      if (load) begin
         {play_code_d, play_dur_d} = mem[rd_ptr_d];
      end
   end

   always_comb begin
      presc_d = '0;
      if (state_d == state_q && !tick) begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_comb begin
      note_d = key_data;
      if (state_q == S_FETCH || state_q == S_PLAY) begin
         note_d = (key_data != 4'd0) ? key_data : play_code_q;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         cur_q       <= '0;
         dur_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         entry_cnt_q <= '0;
         rec_full_q  <= 1'b0;
         play_code_q <= '0;
         play_dur_q  <= '0;
         note_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         cur_q       <= cur_d;
         dur_q       <= dur_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         entry_cnt_q <= entry_cnt_d;
         rec_full_q  <= rec_full_d;
         play_code_q <= play_code_d;
         play_dur_q  <= play_dur_d;
         note_q      <= note_d;
         busy_q      <= busy_d;
      end
   end

   assign note_data = note_q;
   assign busy      = busy_q;
   assign rec_full  = rec_full_q;
   assign entry_cnt = entry_cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with DEPTH=4, TICK_DIV=4: vector table for IDLE behaviour,
// scoreboarded record/playback sequences, override, split/full, mid-play reset.
module tb_note_sequencer;

   localparam int DEPTH    = 4;
   localparam int AW       = 2;
   localparam int TICK_DIV = 4;
`ifdef NOTE_SEQ_LOOP_EN
   localparam int END_ST = 2;
`else
   localparam int END_ST = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    key_data;
   logic          rec_btn;
   logic          play_btn;
   logic          stop_btn;
   logic [3:0]    note_data;
   logic          busy;
   logic          rec_full;
   logic [AW:0]   entry_cnt;
   logic [1:0]    state;

   note_sequencer #(.DEPTH(DEPTH), .AW(AW), .TICK_DIV(TICK_DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_data  (key_data),
      .rec_btn   (rec_btn),
      .play_btn  (play_btn),
      .stop_btn  (stop_btn),
      .note_data (note_data),
      .busy      (busy),
      .rec_full  (rec_full),
      .entry_cnt (entry_cnt),
      .state     (state)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_q[$];
   int         seg_code[3];
   int         seg_len[3];

   typedef struct {
      logic [3:0] key;
      logic       rec;
      logic       play;
      logic       stop;
      int         st;
      int         bsy;
      int         note;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic [3:0] k, input logic r, input logic p, input logic s);
      key_data = k;
      rec_btn  = r;
      play_btn = p;
      stop_btn = s;
      @(posedge clk);
      #1;
   endtask

   task automatic rec_hold(input logic [3:0] k, input int n);
      logic [3:0] e;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(k);
         step(k, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         check("rec_note", note_data, e);
      end
   endtask

   // Expected note_data k cycles after the play_btn edge, from the segment table.
   function automatic int exp_play(input int k, input int total);
      int idx;
      if (k == 0) return 0;
      idx = k - 1;
      if (idx >= total) begin
`ifdef NOTE_SEQ_LOOP_EN
         idx = idx % total;
`else
         return 0;
`endif
      end
      for (int i = 0; i < 3; i++) begin
         if (idx < seg_len[i]) return seg_code[i];
         idx -= seg_len[i];
      end
      return 0;
   endfunction

   task automatic play_run(input int total, input int nsteps, input int fetch_k,
                           input int ovr_lo, input int ovr_hi, input int stop_at);
      logic [3:0] kv;
      logic [3:0] e;
      for (int k = 0; k <= nsteps; k++) begin
         kv = (k >= ovr_lo && k <= ovr_hi) ? 4'd7 : 4'd0;
         if (k >= ovr_lo && k <= ovr_hi) e = 4'd7;
         else if (k > stop_at)           e = 4'd0;
         else                            e = 4'(exp_play(k, total));
         exp_q.push_back(e);
         step(kv, 1'b0, k == 0, k == stop_at);
         e = exp_q.pop_front();
         check("play_note", note_data, e);
         if (k == 0) check("play_start_state", state, 2);
         if (k == fetch_k && k < stop_at) check("play_fetch_state", state, 2);
         if (k == stop_at) begin
            check("stop_state", state, 0);
            check("stop_busy", busy, 0);
         end else if (stop_at > total) begin
            if (k == total - 1) check("play_last_state", state, 3);
            if (k == total)     check("seq_end_state", state, END_ST);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      key_data = 4'd0;
      rec_btn  = 1'b0;
      play_btn = 1'b0;
      stop_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state, 0);
      check("rst_note", note_data, 0);
      check("rst_busy", busy, 0);
      check("rst_full", rec_full, 0);
      check("rst_cnt", entry_cnt, 0);
      rst_n = 1'b1;

      // IDLE passthrough, empty play, coincident buttons
      vecs[0] = '{4'd5, 1'b0, 1'b0, 1'b0, 0, 0, 5};
      vecs[1] = '{4'd9, 1'b0, 1'b0, 1'b0, 0, 0, 9};
      vecs[2] = '{4'd0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
      vecs[3] = '{4'd2, 1'b1, 1'b1, 1'b1, 0, 0, 2};
      vecs[4] = '{4'd0, 1'b1, 1'b0, 1'b1, 0, 0, 0};
      vecs[5] = '{4'd0, 1'b0, 1'b1, 1'b1, 0, 0, 0};
      vecs[6] = '{4'd3, 1'b0, 1'b0, 1'b0, 0, 0, 3};
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].key, vecs[i].rec, vecs[i].play, vecs[i].stop);
         check("vec_state", state, vecs[i].st);
         check("vec_busy", busy, vecs[i].bsy);
         check("vec_note", note_data, vecs[i].note);
      end

      // Record {3,3},{0,2},{5,4}
      step(4'd0, 1'b1, 1'b0, 1'b0);
      check("rec_enter_state", state, 1);
      check("rec_enter_busy", busy, 1);
      check("rec_enter_cnt", entry_cnt, 0);
      rec_hold(4'd3, 12);
      rec_hold(4'd0, 8);
      rec_hold(4'd5, 16);
      check("rec_mid_state", state, 1);
      check("rec_mid_cnt", entry_cnt, 2);
      step(4'd0, 1'b1, 1'b0, 1'b0);
      check("rec_done_state", state, 0);
      check("rec_done_busy", busy, 0);
      check("rec_done_cnt", entry_cnt, 3);
      check("rec_done_full", rec_full, 0);

      // Playback, then playback with live override on code 5
      seg_code = '{3, 0, 5};
      seg_len  = '{13, 9, 17};
      play_run(39, 44, 13, -1, -2, 44);
      play_run(39, 44, 13, 26, 30, 44);

      // Asynchronous reset in the middle of PLAY
      step(4'd0, 1'b0, 1'b1, 1'b0);
      repeat (5) step(4'd0, 1'b0, 1'b0, 1'b0);
      check("pre_rst_note", note_data, 3);
      rst_n = 1'b0;
      #2;
      check("midrst_state", state, 0);
      check("midrst_note", note_data, 0);
      check("midrst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(4'd0, 1'b0, 1'b0, 1'b0);
      check("postrst_cnt", entry_cnt, 0);
      check("postrst_state", state, 0);

      // Long note split at 15 ticks, then fill memory
      step(4'd0, 1'b1, 1'b0, 1'b0);
      rec_hold(4'd2, 70);
      check("split_cnt", entry_cnt, 1);
      check("split_full", rec_full, 0);
      check("split_state", state, 1);
      rec_hold(4'd4, 8);
      check("fill_cnt2", entry_cnt, 2);
      rec_hold(4'd6, 8);
      check("fill_cnt3", entry_cnt, 3);
      step(4'd0, 1'b0, 1'b0, 1'b0);
      check("full_state", state, 0);
      check("full_flag", rec_full, 1);
      check("full_cnt", entry_cnt, 4);
      check("full_busy", busy, 0);

      seg_code = '{2, 4, 6};
      seg_len  = '{70, 9, 9};
      play_run(88, 92, 61, -1, -2, 92);
      play_run(88, 12, 61, -1, -2, 10);

      // Fresh recording aborted empty; play must be ignored
      step(4'd0, 1'b1, 1'b0, 1'b0);
      check("empty_rec_state", state, 1);
      check("empty_rec_full", rec_full, 0);
      step(4'd0, 1'b0, 1'b0, 1'b1);
      check("empty_stop_state", state, 0);
      check("empty_cnt", entry_cnt, 0);
      step(4'd0, 1'b0, 1'b1, 1'b0);
      check("empty_play_state", state, 0);
      check("empty_play_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Controller that owns the 4-bit note code driving the piezo note generator.
- Shares the generator between live keypad input and an internal record/playback engine; live keys always win.
- Records keypad notes with durations quantised to tempo ticks into a small on-chip memory, then replays them.
- Sits between the keypad decoder and the note generator's data input.

Parameters:
- DEPTH, 16, number of note entries in sequence memory
- AW, 4, address width, log2(DEPTH)
- TICK_DIV, 25000, clk cycles per tempo tick (>=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_data  in  4  live keypad note code, 0 = no key / rest
- rec_btn  in  1  single-cycle pulse, synchronised: start/stop recording
- play_btn  in  1  single-cycle pulse: start playback
- stop_btn  in  1  single-cycle pulse: abort current mode
- note_data  out  4  registered note code to note generator
- busy  out  1  high in REC, FETCH, PLAY
- rec_full  out  1  sticky: last recording filled memory
- entry_cnt  out  AW+1  number of valid recorded entries
- state  out  2  IDLE=0, REC=1, FETCH=2, PLAY=3

Behaviour:
- Reset (async, rst_n=0): state IDLE, note_data 0, busy 0, rec_full 0, entry_cnt 0, pointers/counters 0. Memory contents not cleared.
- Memory entry = {code[3:0], dur[3:0]}; dur 1..15 ticks. Write is synchronous; read is registered with 1-cycle latency.
- Tick: prescaler counts 0..TICK_DIV-1; tick pulses one cycle at TICK_DIV-1. Prescaler clears on every state entry.
- Button priority when pulses coincide: stop > rec > play.
- note_data source:
  - IDLE, REC: key_data, registered (1-cycle latency).
  - FETCH, PLAY: key_data if nonzero (live override); otherwise the current playback code. Playback timing is unaffected by override.
- IDLE:
  - rec_btn -> REC. Clears entry_cnt, wr_ptr and rec_full. Loads cur=key_data, dur=0.
  - play_btn with entry_cnt>0 -> FETCH, rd_ptr=0.
  - play_btn with entry_cnt==0 -> ignored.
- REC:
  - Each tick: dur++.
  - When key_data != cur: if dur>0, write {cur,dur} and entry_cnt++. Then cur=key_data, dur=0. Changes shorter than one tick (dur==0) are dropped.
  - Leading rests (cur==0 while entry_cnt==0) are never written.
  - dur reaching 15: write {cur,15}, dur=0, cur unchanged (long notes split).
  - After any write that makes entry_cnt==DEPTH: rec_full=1 -> IDLE.
  - stop_btn or rec_btn: flush the pending {cur,dur} if dur>0 and it is not a leading rest (space is guaranteed) -> IDLE.
  - A flush and a key-change write never both occur in the same cycle; the button wins.
- FETCH: one cycle for the memory read -> PLAY. Loads play_code and play_dur from memory; prescaler cleared.
- PLAY:
  - Each tick: play_dur--.
  - When play_dur reaches 0 on a tick: if rd_ptr==entry_cnt-1, end of sequence; else rd_ptr++ -> FETCH.
  - End of sequence -> IDLE (see LOOP_EN).
  - stop_btn in FETCH/PLAY -> IDLE next cycle.
  - rec_btn and play_btn are ignored in FETCH/PLAY.
- Nominal length per entry: dur*TICK_DIV + 1 cycles (FETCH adds 1).
- busy = (state != IDLE), registered with state.

Optional Feature:
- Macro NOTE_SEQ_LOOP_EN.
- Defined: end of sequence -> FETCH with rd_ptr=0; playback repeats until stop_btn.
- Undefined: end of sequence -> IDLE; note_data falls back to key_data.

Test Plan:
- Reset, TICK_DIV=4: rst_n low mid-PLAY -> state 0, note_data 0, busy 0 immediately; entry_cnt 0 after release.
- Record: rec_btn; key 3 for 12 cycles, key 0 for 8, key 5 for 16; rec_btn -> memory {3,3},{0,2},{5,4}; entry_cnt 3; state IDLE.
- Playback of the above: play_btn -> note_data 3 for 13 cycles, 0 for 9, 5 for 17, then IDLE; busy drops.
- Override: during playback of code 5, key_data 7 for 5 cycles -> note_data 7 for those cycles (1-cycle lag), then 5; total play time unchanged.
- Full/split: DEPTH=4, hold key 2 for 70 cycles (17.5 ticks) -> entries {2,15}, then full not reached; continue keys until 4 entries -> rec_full 1, auto IDLE; play_btn with entry_cnt 0 after fresh rec_btn+stop_btn -> ignored.
- Simultaneous rec_btn+play_btn+stop_btn in IDLE -> stays IDLE; with NOTE_SEQ_LOOP_EN, 2-entry sequence replays entry 0 after entry 1 until stop_btn.
